// File: rtl/sdmf_pkg.sv
// Shared definitions for the SDMF frame generator: FSM encoding,
// tdata field placement and the payload LFSR constants/step function.
package sdmf_pkg;

  // Frame generator sequencing states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } sdmf_state_e;

  // tdata layout: payload byte at the bottom, then t, then s, zero above
  localparam int TDATA_BYTE_LSB = 0;
  localparam int TDATA_BYTE_W   = 8;
  localparam int TDATA_T_LSB    = 8;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, right-shifting form:
  // feedback = q[0]^q[2]^q[3]^q[5], inserted at bit 15
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/sdmf_frame_gen_if.sv
// Frame/stream bus between the SDMF generator (master) and the SDMF
// ingress under test (slave): frame window, header strobe with frame
// indices, and the AXI-Stream beat channel.
interface sdmf_frame_gen_if #(
  parameter int FDSTI_WIDTH = 32,
  parameter int FDSSI_WIDTH = 2,
  parameter int DATA_WIDTH  = 24
);
  logic                   frame_valid;
  logic                   FI_valid;
  logic [FDSTI_WIDTH-1:0] FDSTI;
  logic [FDSSI_WIDTH-1:0] FDSSI;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic [DATA_WIDTH-1:0]  tdata;

  modport master (
    output frame_valid, FI_valid, FDSTI, FDSSI, tvalid, tlast, tdata,
    input  tready
  );

  modport slave (
    input  frame_valid, FI_valid, FDSTI, FDSSI, tvalid, tlast, tdata,
    output tready
  );
endinterface

// File: rtl/sdmf_lfsr16.sv
// 16-bit payload LFSR: loads the seed, advances one step per accepted beat.
module sdmf_lfsr16
  import sdmf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;

  // Seed on load, otherwise step when a beat is consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'h0000;
    end else if (load_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/sdmf_frame_gen.sv
// SDMF frame generator: emits a run of num_frames frames, each a
// frame_valid window opened by a 1-cycle FI_valid header followed by
// 2^(S_BITS+T_BITS) AXI-S beats, with gap_cycles extra idle cycles
// between frames. Frame indices and payload come from a free-running
// beat counter that only reset clears.
// Optional build macro SDMF_GEN_LFSR_EN adds lfsr_mode_i, selecting an
// LFSR payload byte instead of the counter byte.
module sdmf_frame_gen
  import sdmf_pkg::*;
#(
  parameter int FDSTI_WIDTH = 32,
  parameter int FDSSI_WIDTH = 2,
  parameter int DATA_WIDTH  = 24,
  parameter int S_BITS      = 2,
  parameter int T_BITS      = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] num_frames_i,
  input  logic [GAP_WIDTH-1:0] gap_cycles_i,
`ifdef SDMF_GEN_LFSR_EN
  input  logic                 lfsr_mode_i,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] frames_sent_o,
  sdmf_frame_gen_if.master     bus
);

  localparam int ST_W = S_BITS + T_BITS;
  localparam int BC_W = FDSTI_WIDTH + FDSSI_WIDTH + ST_W;

  sdmf_state_e          state_q;
  logic [BC_W-1:0]      bc_q;
  logic [BC_W-1:0]      bc_d;
  logic [CNT_WIDTH-1:0] frames_sent_q;
  logic [CNT_WIDTH-1:0] num_frames_q;
  logic [GAP_WIDTH-1:0] gap_cycles_q;
  logic [GAP_WIDTH-1:0] gap_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 frame_valid_q;
  logic                 fi_valid_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 beat_acc_s;
  logic                 start_ok_s;
  logic [7:0]           low_byte_s;
  logic [DATA_WIDTH-1:0] tdata_s;

  assign beat_acc_s = tvalid_q & bus.tready;
  assign start_ok_s = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // Beat counter advance: one step per accepted beat, natural wrap
  always_comb begin
    bc_d = bc_q;
    if (beat_acc_s) begin
      bc_d = bc_q + BC_W'(1);
    end else begin
      bc_d = bc_q;
    end
  end

  // Free-running beat counter register, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bc_q <= '0;
    end else begin
      bc_q <= bc_d;
    end
  end

  // Run sequencing with registered framing, status and handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      frames_sent_q <= '0;
      num_frames_q  <= '0;
      gap_cycles_q  <= '0;
      gap_cnt_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      fi_valid_q    <= 1'b0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok_s) begin
            num_frames_q  <= num_frames_i;
            gap_cycles_q  <= gap_cycles_i;
            frames_sent_q <= '0;
            if (num_frames_i == '0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q       <= ST_HDR;
              busy_q        <= 1'b1;
              done_q        <= 1'b0;
              frame_valid_q <= 1'b1;
              fi_valid_q    <= 1'b1;
            end
          end
        end
        ST_HDR: begin
          state_q    <= ST_DATA;
          fi_valid_q <= 1'b0;
          tvalid_q   <= 1'b1;
          tlast_q    <= &bc_q[ST_W-1:0];
        end
        ST_DATA: begin
          if (beat_acc_s) begin
            if (tlast_q) begin
              frames_sent_q <= frames_sent_q + CNT_WIDTH'(1);
              tvalid_q      <= 1'b0;
              tlast_q       <= 1'b0;
              frame_valid_q <= 1'b0;
              if (frames_sent_q + CNT_WIDTH'(1) == num_frames_q) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ST_GAP;
                gap_cnt_q <= gap_cycles_q;
              end
            end else begin
              tlast_q <= &bc_d[ST_W-1:0];
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q       <= ST_HDR;
            frame_valid_q <= 1'b1;
            fi_valid_q    <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SDMF_GEN_LFSR_EN
  logic [15:0] lfsr_s;
  logic        lfsr_mode_q;

  sdmf_lfsr16 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (start_ok_s),
    .step_i (beat_acc_s),
    .q_o    (lfsr_s)
  );

  // Payload mode is fixed for the duration of a run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_mode_q <= 1'b0;
    end else if (start_ok_s) begin
      lfsr_mode_q <= lfsr_mode_i;
    end
  end

  assign low_byte_s = lfsr_mode_q ? lfsr_s[7:0] : bc_q[7:0];
`else
  assign low_byte_s = bc_q[7:0];
`endif

  // Assemble tdata from the beat counter fields; upper bits stay zero
  always_comb begin
    tdata_s = '0;
    tdata_s[TDATA_BYTE_LSB +: TDATA_BYTE_W]  = low_byte_s;
    tdata_s[TDATA_T_LSB +: T_BITS]           = bc_q[0 +: T_BITS];
    tdata_s[TDATA_T_LSB + T_BITS +: S_BITS]  = bc_q[T_BITS +: S_BITS];
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.FI_valid    = fi_valid_q;
  assign bus.FDSSI       = bc_q[ST_W +: FDSSI_WIDTH];
  assign bus.FDSTI       = bc_q[ST_W + FDSSI_WIDTH +: FDSTI_WIDTH];
  assign bus.tvalid      = tvalid_q;
  assign bus.tlast       = tlast_q;
  assign bus.tdata       = tdata_s;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign frames_sent_o   = frames_sent_q;

endmodule

// File: tb/tb_sdmf_frame_gen.sv
// Self-checking bench for sdmf_frame_gen with a beat-level reference
// model: expected payload/indices come from the count of accepted beats.
module tb_sdmf_frame_gen;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] num_frames_i = 16'd0;
  logic [7:0]  gap_cycles_i = 8'd0;
`ifdef SDMF_GEN_LFSR_EN
  logic        lfsr_mode_i = 1'b0;
`endif
  logic        busy_o;
  logic        done_o;
  logic [15:0] frames_sent_o;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned bc_m = 0;
  int unsigned     lfsr_m = 0;

  sdmf_frame_gen_if #(.FDSTI_WIDTH(32), .FDSSI_WIDTH(2), .DATA_WIDTH(24)) bus ();

  sdmf_frame_gen #(
    .FDSTI_WIDTH(32), .FDSSI_WIDTH(2), .DATA_WIDTH(24),
    .S_BITS(2), .T_BITS(2), .CNT_WIDTH(16), .GAP_WIDTH(8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .num_frames_i  (num_frames_i),
    .gap_cycles_i  (gap_cycles_i),
`ifdef SDMF_GEN_LFSR_EN
    .lfsr_mode_i   (lfsr_mode_i),
`endif
    .busy_o        (busy_o),
    .done_o        (done_o),
    .frames_sent_o (frames_sent_o),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_tdata(input longint unsigned bc, input int unsigned lf, input bit lm);
    int unsigned idx;
    int unsigned low;
    idx = int'(bc % B);
    low = lm ? (lf % 256) : int'(bc % 256);
    return 24'(low + (idx % 4) * 256 + (idx / 4) * 1024);
  endfunction

  function automatic int unsigned lfsr_step(input int unsigned q);
    int unsigned fb;
    fb = (q ^ (q >> 2) ^ (q >> 3) ^ (q >> 5)) & 1;
    return (q >> 1) | (fb << 15);
  endfunction

  // Drive one run and check every cycle against the beat model.
  // mode: 0 full tready, 1 alternating, 2 random. abort_beat>=0 resets mid-run.
  task automatic run_frames(input string name, input int n, input int gap, input int mode,
                            input bit lm, input int abort_beat, input bit poke);
    int done_cyc, fi_cnt, beats, low_run, exp_done;
    bit prev_fv, seen_fv, prev_stall, prev_tl, fv, fi, tv, tl;
    logic [23:0] prev_td, td;
    logic [1:0]  prev_ss;
    logic [31:0] prev_st;
    done_cyc = -1; fi_cnt = 0; beats = 0; low_run = 0;
    prev_fv = 0; seen_fv = 0; prev_stall = 0; prev_tl = 0;
    prev_td = '0; prev_ss = '0; prev_st = '0;
    @(negedge clk);
    start_i = 1'b1; num_frames_i = 16'(n); gap_cycles_i = 8'(gap);
`ifdef SDMF_GEN_LFSR_EN
    lfsr_mode_i = lm;
`endif
    @(posedge clk);
    lfsr_m = 32'hACE1;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start_i = 1'b0;
        num_frames_i = 16'($urandom);
        gap_cycles_i = 8'($urandom);
      end
      if (poke) start_i = (cyc == 30);
      fv = bus.frame_valid; fi = bus.FI_valid; tv = bus.tvalid; tl = bus.tlast; td = bus.tdata;
      if (done_o === 1'b1) begin done_cyc = cyc; break; end
      n_checks++;
      if (busy_o !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b expected 1 (cycle %0d)", name, busy_o, cyc); end
      n_checks++;
      if (fi !== (fv && !prev_fv)) begin n_fail++; $display("FAIL %s FI_valid: got %b expected %b (cycle %0d)", name, fi, fv && !prev_fv, cyc); end
      n_checks++;
      if ((tv && (!fv || fi)) !== 1'b0) begin n_fail++; $display("FAIL %s tvalid_window: tvalid %b frame_valid %b FI_valid %b", name, tv, fv, fi); end
      if (fv) begin
        n_checks++;
        if (bus.FDSSI !== 2'((bc_m / B) % 4)) begin n_fail++; $display("FAIL %s FDSSI: got %0d expected %0d", name, bus.FDSSI, (bc_m / B) % 4); end
        n_checks++;
        if (bus.FDSTI !== 32'(bc_m / (B * 4))) begin n_fail++; $display("FAIL %s FDSTI: got %0d expected %0d", name, bus.FDSTI, bc_m / (B * 4)); end
      end
      if (prev_stall) begin
        n_checks++;
        if (td !== prev_td || tl !== prev_tl || bus.FDSSI !== prev_ss || bus.FDSTI !== prev_st) begin
          n_fail++; $display("FAIL %s stall_stable: tdata %h was %h tlast %b was %b", name, td, prev_td, tl, prev_tl);
        end
      end
      if (fi) fi_cnt++;
      if (!fv) low_run++;
      else begin
        if (fi && seen_fv) begin
          n_checks++;
          if (low_run !== gap + 1) begin n_fail++; $display("FAIL %s gap_len: got %0d expected %0d", name, low_run, gap + 1); end
        end
        low_run = 0; seen_fv = 1;
      end
      if (tv) begin
        n_checks++;
        if (td !== exp_tdata(bc_m, lfsr_m, lm)) begin n_fail++; $display("FAIL %s tdata: got %h expected %h (beat %0d)", name, td, exp_tdata(bc_m, lfsr_m, lm), beats); end
        n_checks++;
        if (tl !== ((bc_m % B) == B - 1)) begin n_fail++; $display("FAIL %s tlast: got %b expected %b (beat %0d)", name, tl, (bc_m % B) == B - 1, beats); end
      end
      if (tv && abort_beat >= 0 && beats == abort_beat) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.frame_valid, bus.FI_valid, bus.tvalid, bus.tlast, busy_o, done_o} !== 6'b0 ||
            bus.tdata !== 24'd0 || bus.FDSTI !== 32'd0 || bus.FDSSI !== 2'd0 || frames_sent_o !== 16'd0) begin
          n_fail++; $display("FAIL %s reset_outputs: fv %b tv %b busy %b tdata %h FDSSI %0d sent %0d expected all 0",
                             name, bus.frame_valid, bus.tvalid, busy_o, bus.tdata, bus.FDSSI, frames_sent_o);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0; bc_m = 0; start_i = 1'b0; bus.tready = 1'b1;
        return;
      end
      case (mode)
        0: bus.tready = 1'b1;
        1: bus.tready = (cyc % 2 == 1);
        default: bus.tready = 1'($urandom);
      endcase
      if (tv && bus.tready) begin
        beats++; bc_m++; lfsr_m = lfsr_step(lfsr_m);
      end
      prev_stall = tv && !bus.tready;
      prev_td = td; prev_tl = tl; prev_ss = bus.FDSSI; prev_st = bus.FDSTI; prev_fv = fv;
    end
    start_i = 1'b0; bus.tready = 1'b1;
    n_checks++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL %s timeout: done never seen, expected within 4000 cycles", name); end
    if (mode == 0) begin
      exp_done = n * (B + 1) + (n - 1) * (1 + gap) + 1;
      n_checks++;
      if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done); end
    end
    n_checks++;
    if (fi_cnt !== n) begin n_fail++; $display("FAIL %s header_count: got %0d expected %0d", name, fi_cnt, n); end
    n_checks++;
    if (beats !== n * B) begin n_fail++; $display("FAIL %s beat_count: got %0d expected %0d", name, beats, n * B); end
    n_checks++;
    if (frames_sent_o !== 16'(n)) begin n_fail++; $display("FAIL %s frames_sent: got %0d expected %0d", name, frames_sent_o, n); end
    n_checks++;
    if (busy_o !== 1'b0 || bus.frame_valid !== 1'b0 || bus.tvalid !== 1'b0) begin
      n_fail++; $display("FAIL %s end_state: busy %b fv %b tvalid %b expected 0", name, busy_o, bus.frame_valid, bus.tvalid);
    end
  endtask

  task automatic test_reset();
    bus.tready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.frame_valid, bus.FI_valid, bus.tvalid, bus.tlast, busy_o, done_o} !== 6'b0 ||
        bus.tdata !== 24'd0 || bus.FDSTI !== 32'd0 || bus.FDSSI !== 2'd0 || frames_sent_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_values: fv %b fi %b tv %b busy %b done %b tdata %h expected all 0",
                         bus.frame_valid, bus.FI_valid, bus.tvalid, busy_o, done_o, bus.tdata);
    end
    reset = 1'b0;
    bc_m = 0;
  endtask

  task automatic test_zero_frames();
    @(negedge clk);
    start_i = 1'b1; num_frames_i = 16'd0; gap_cycles_i = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL zero_frames done: got done %b busy %b expected 1 0", done_o, busy_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.frame_valid !== 1'b0 || bus.tvalid !== 1'b0 || frames_sent_o !== 16'd0) begin
        n_fail++; $display("FAIL zero_frames idle: fv %b tvalid %b sent %0d expected 0", bus.frame_valid, bus.tvalid, frames_sent_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    run_frames("basic", 3, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frames("backpressure", 3, 0, 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_gap();
    run_frames("gap5", 2, 5, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_busy_start();
    run_frames("busy_start", 3, 1, 2, 1'b0, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      run_frames("random", int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 2, 1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    run_frames("mid_reset", 3, 0, 0, 1'b0, B + 7, 1'b0);
    run_frames("after_reset", 1, 0, 0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_lfsr();
`ifdef SDMF_GEN_LFSR_EN
    run_frames("lfsr", 2, 1, 2, 1'b1, -1, 1'b0);
    run_frames("lfsr_off", 1, 0, 0, 1'b0, -1, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_zero_frames();
    test_basic();
    test_backpressure();
    test_gap();
    test_busy_start();
    test_random();
    test_mid_reset();
    test_lfsr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
